// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and sizing helpers for the SDRAM host-port arbiter
package sdram_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int DATA_BITS = 16;

   // Index width for a port number; never below one bit so 2-port builds still have a select line.
   function automatic int port_idx_w(input int num_ports);
      return (num_ports > 2) ? $clog2(num_ports) : 1;
   endfunction

   function automatic int addr_lsb(input int port, input int addr_bits);
      return port * addr_bits;
   endfunction

   function automatic int data_lsb(input int port);
      return port * DATA_BITS;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational picker: first pending port at or after the pointer, wrapping
module rr_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int IDX_W     = port_idx_w(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] pending,
   input  logic [IDX_W-1:0]     ptr,
   output logic                 any_valid,
   output logic [IDX_W-1:0]     index
);

   logic [IDX_W:0]   cand;
   logic [IDX_W-1:0] cand_idx;

   // Scan from the farthest offset down so the nearest pending port is the last write and wins.
   always_comb begin
      any_valid = 1'b0;
      index     = '0;
      cand      = '0;
      cand_idx  = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (cand >= (IDX_W + 1)'(NUM_PORTS)) begin
            cand = cand - (IDX_W + 1)'(NUM_PORTS);
         end
         cand_idx = cand[IDX_W-1:0];
         if (pending[cand_idx]) begin
            any_valid = 1'b1;
            index     = cand_idx;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin sharing of one SDRAM controller host port over toggle handshakes
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_BITS = 22
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_PORTS-1:0]           up_req,
   input  logic [NUM_PORTS-1:0]           up_we,
   input  logic [NUM_PORTS*ADDR_BITS-1:0] up_address,
   input  logic [NUM_PORTS*DATA_BITS-1:0] up_data_write,
   input  logic [NUM_PORTS-1:0]           up_refresh,
   output logic [NUM_PORTS-1:0]           up_ack,
   output logic [NUM_PORTS*DATA_BITS-1:0] up_data_read,
   output logic                           dn_req,
   output logic                           dn_we,
   output logic [ADDR_BITS-1:0]           dn_address,
   output logic [DATA_BITS-1:0]           dn_data_write,
   output logic                           dn_refresh,
   input  logic                           dn_ack,
   input  logic [DATA_BITS-1:0]           dn_data_read
);

   localparam int IDX_W = port_idx_w(NUM_PORTS);

   arb_state_t           state;
   arb_state_t           next_state;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     grant;
   logic [IDX_W-1:0]     pick;
   logic                 any_valid;
   logic                 launch;
   logic                 complete;
   logic [NUM_PORTS-1:0] pending;

   logic [ADDR_BITS-1:0] addr_arr  [NUM_PORTS];
   logic [DATA_BITS-1:0] wdata_arr [NUM_PORTS];
   logic [DATA_BITS-1:0] rdata_arr [NUM_PORTS];

   assign pending = up_req ^ up_ack;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign addr_arr[i]  = up_address[addr_lsb(i, ADDR_BITS) +: ADDR_BITS];
      assign wdata_arr[i] = up_data_write[data_lsb(i) +: DATA_BITS];
      assign up_data_read[data_lsb(i) +: DATA_BITS] = rdata_arr[i];
   end

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_rr (
      .pending   (pending),
      .ptr       (rr_ptr),
      .any_valid (any_valid),
      .index     (pick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      launch     = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (any_valid) begin
               launch     = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY: begin
            if (dn_ack == dn_req) begin
               complete   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Downstream fields only move on launch so the controller sees them stable for the whole transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant         <= '0;
         rr_ptr        <= '0;
         dn_req        <= 1'b0;
         dn_we         <= 1'b0;
         dn_address    <= '0;
         dn_data_write <= '0;
         dn_refresh    <= 1'b0;
         up_ack        <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            rdata_arr[i] <= '0;
         end
      end else begin
         dn_refresh <= |up_refresh;
         if (launch) begin
            grant         <= pick;
            dn_we         <= up_we[pick];
            dn_address    <= addr_arr[pick];
            dn_data_write <= wdata_arr[pick];
            dn_req        <= ~dn_req;
         end
         if (complete) begin
            if (!dn_we) begin
               rdata_arr[grant] <= dn_data_read;
            end
            up_ack[grant] <= ~up_ack[grant];
            rr_ptr        <= (grant == IDX_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter against a transaction-level model
module tb_sdram_arbiter;

   localparam int NP = 3;
   localparam int AB = 22;

   logic             clk = 1'b0;
   logic             reset;
   logic [NP-1:0]    up_req, up_we, up_refresh, up_ack;
   logic [NP*AB-1:0] up_address;
   logic [NP*16-1:0] up_data_write, up_data_read;
   logic             dn_req, dn_we, dn_refresh, dn_ack;
   logic [AB-1:0]    dn_address;
   logic [15:0]      dn_data_write, dn_data_read;

   sdram_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB)) dut (
      .clk           (clk),
      .reset         (reset),
      .up_req        (up_req),
      .up_we         (up_we),
      .up_address    (up_address),
      .up_data_write (up_data_write),
      .up_refresh    (up_refresh),
      .up_ack        (up_ack),
      .up_data_read  (up_data_read),
      .dn_req        (dn_req),
      .dn_we         (dn_we),
      .dn_address    (dn_address),
      .dn_data_write (dn_data_write),
      .dn_refresh    (dn_refresh),
      .dn_ack        (dn_ack),
      .dn_data_read  (dn_data_read)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: what each port and the controller should observe.
   logic [NP-1:0] m_ack;
   logic [15:0]   m_rd [NP];
   int            m_ptr;
   bit            m_busy;
   int            m_grant;
   logic          m_dn_req, m_dn_we, m_refresh;
   logic [AB-1:0] m_dn_addr;
   logic [15:0]   m_dn_wd;
   int            order[$];

   int          lat;
   int          ctl_lat_fixed = -1;
   bit          ctl_data_fixed = 0;
   logic [15:0] ctl_data_val = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int first_pending(input logic [NP-1:0] pend, input int ptr);
      for (int k = 0; k < NP; k++) begin
         if (pend[(ptr + k) % NP]) return (ptr + k) % NP;
      end
      return -1;
   endfunction

   function automatic logic [NP*16-1:0] model_rd_bus();
      logic [NP*16-1:0] v;
      for (int i = 0; i < NP; i++) v[i*16 +: 16] = m_rd[i];
      return v;
   endfunction

   task automatic model_reset();
      m_ack = '0; m_ptr = 0; m_busy = 0; m_grant = 0;
      m_dn_req = 0; m_dn_we = 0; m_dn_addr = '0; m_dn_wd = '0; m_refresh = 0;
      for (int i = 0; i < NP; i++) m_rd[i] = '0;
      lat = 0;
   endtask

   task automatic request(input int p, input logic we, input logic [AB-1:0] a, input logic [15:0] d);
      up_we[p] = we;
      up_address[p*AB +: AB] = a;
      up_data_write[p*16 +: 16] = d;
      up_req[p] = ~up_req[p];
   endtask

   task automatic tick();
      logic [NP-1:0] pend;
      logic [15:0]   rd_before;
      logic          ref_before;
      bit            launch, complete;
      int            p;
      pend       = up_req ^ m_ack;
      ref_before = |up_refresh;
      rd_before  = dn_data_read;
      launch     = 0;
      complete   = 0;
      p          = -1;
      if (!m_busy) begin
         p      = first_pending(pend, m_ptr);
         launch = (p >= 0);
      end else begin
         complete = (dn_ack == m_dn_req);
      end
      @(posedge clk);
      #1;
      m_refresh = ref_before;
      if (complete) begin
         if (!m_dn_we) m_rd[m_grant] = rd_before;
         m_ack[m_grant] = ~m_ack[m_grant];
         m_ptr  = (m_grant + 1) % NP;
         m_busy = 0;
      end
      if (launch) begin
         m_grant   = p;
         m_dn_we   = up_we[p];
         m_dn_addr = up_address[p*AB +: AB];
         m_dn_wd   = up_data_write[p*16 +: 16];
         m_dn_req  = ~m_dn_req;
         m_busy    = 1;
         lat       = (ctl_lat_fixed >= 0) ? ctl_lat_fixed : int'($urandom_range(0, 4));
         order.push_back(p);
      end
      chk("dn_req", dn_req, m_dn_req);
      chk("dn_we", dn_we, m_dn_we);
      chk("dn_address", dn_address, m_dn_addr);
      chk("dn_data_write", dn_data_write, m_dn_wd);
      chk("dn_refresh", dn_refresh, m_refresh);
      chk("up_ack", up_ack, m_ack);
      chk("up_data_read", up_data_read, model_rd_bus());
      // Controller model: answer the outstanding request after its latency.
      if (dn_ack != dn_req) begin
         if (lat == 0) begin
            dn_ack = dn_req;
            dn_data_read = ctl_data_fixed ? ctl_data_val : 16'($urandom);
         end else begin
            lat--;
         end
      end
   endtask

   task automatic wait_done(input int limit);
      int c;
      c = 0;
      while ((m_busy || ((up_req ^ m_ack) != '0)) && c < limit) begin
         tick();
         c++;
      end
      n_checks++;
      assert (c < limit) else begin
         n_fail++;
         $error("FAIL wait_done cycles=%0d limit=%0d", c, limit);
      end
   endtask

   initial begin
      int pos0;
      int streamed;
      reset = 1'b1;
      up_req = '0; up_we = '0; up_refresh = '0;
      up_address = '0; up_data_write = '0;
      dn_ack = 1'b0; dn_data_read = '0;
      model_reset();
      #12;
      chk("reset_dn_req", dn_req, 1'b0);
      chk("reset_up_ack", up_ack, '0);
      chk("reset_up_data_read", up_data_read, '0);
      chk("reset_dn_address", dn_address, '0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single read, port 1.
      ctl_lat_fixed = 2; ctl_data_fixed = 1; ctl_data_val = 16'hBEEF;
      request(1, 1'b0, 22'h00123, 16'h0);
      tick();
      chk("t1_dn_req_toggled", dn_req, 1'b1);
      chk("t1_dn_address", dn_address, 22'h00123);
      wait_done(50);
      chk("t1_rd1", up_data_read[31:16], 16'hBEEF);
      chk("t1_rd0_unchanged", up_data_read[15:0], 16'h0000);
      chk("t1_rd2_unchanged", up_data_read[47:32], 16'h0000);
      chk("t1_up_ack", up_ack, 3'b010);

      // Write from port 0.
      ctl_data_val = 16'hDEAD;
      request(0, 1'b1, 22'h3FFFFF, 16'h5A5A);
      tick();
      chk("t2_dn_we", dn_we, 1'b1);
      chk("t2_dn_data_write", dn_data_write, 16'h5A5A);
      chk("t2_dn_address", dn_address, 22'h3FFFFF);
      wait_done(50);
      chk("t2_rd0_kept", up_data_read[15:0], 16'h0000);

      // Bring the pointer back to 0 with a port-2 read.
      ctl_data_fixed = 0; ctl_lat_fixed = -1;
      request(2, 1'b0, 22'h00042, 16'h0);
      wait_done(50);

      // All three at once from pointer 0, then port 0 again while port 2 is in flight.
      order.delete();
      request(0, 1'b0, 22'h00010, 16'h0);
      request(1, 1'b1, 22'h00011, 16'h1111);
      request(2, 1'b0, 22'h00012, 16'h0);
      for (int c = 0; c < 100 && order.size() < 3; c++) tick();
      request(0, 1'b0, 22'h00020, 16'h0);
      wait_done(100);
      chk("t3_order_len", order.size(), 4);
      if (order.size() == 4) begin
         chk("t3_order0", order[0], 0);
         chk("t3_order1", order[1], 1);
         chk("t3_order2", order[2], 2);
         chk("t3_order3", order[3], 0);
      end

      // Port 2 streams while port 0 has one request pending.
      order.delete();
      request(2, 1'b0, 22'h00100, 16'h0);
      request(0, 1'b0, 22'h00200, 16'h0);
      streamed = 1;
      for (int c = 0; c < 300 && ((up_req[0] != m_ack[0]) || streamed < 4); c++) begin
         tick();
         if (up_req[2] == m_ack[2] && streamed < 4) begin
            request(2, 1'b0, 22'(22'h00100 + streamed), 16'h0);
            streamed++;
         end
      end
      wait_done(100);
      pos0 = -1;
      for (int i = order.size() - 1; i >= 0; i--) if (order[i] == 0) pos0 = i;
      chk("t4_port0_served", pos0 >= 0, 1'b1);
      chk("t4_port0_wait", pos0 <= 1, 1'b1);

      // Refresh is a registered OR, independent of transactions.
      up_refresh = 3'b010;
      tick();
      chk("t5_refresh_on", dn_refresh, 1'b1);
      up_refresh = 3'b000;
      tick();
      chk("t5_refresh_off", dn_refresh, 1'b0);

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         for (int p = 0; p < NP; p++) begin
            if (up_req[p] == m_ack[p] && $urandom_range(0, 3) == 0) begin
               request(p, 1'($urandom), 22'($urandom), 16'($urandom));
            end
         end
         up_refresh = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
         tick();
      end
      up_refresh = '0;
      wait_done(200);

      // Reset while busy with dn_req high.
      ctl_lat_fixed = 6;
      for (int k = 0; k < 2; k++) begin
         request(1, 1'b0, 22'h00777, 16'h0);
         tick();
         if (dn_req === 1'b1) break;
         wait_done(50);
      end
      chk("t6_busy_dn_req", dn_req, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_dn_req", dn_req, 1'b0);
      chk("t6_rst_dn_address", dn_address, '0);
      chk("t6_rst_dn_we", dn_we, 1'b0);
      chk("t6_rst_up_ack", up_ack, '0);
      chk("t6_rst_up_data_read", up_data_read, '0);
      up_req = '0; dn_ack = 1'b0; up_refresh = '0;
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      ctl_lat_fixed = 1; ctl_data_fixed = 1; ctl_data_val = 16'h1234;
      request(1, 1'b0, 22'h00321, 16'h0);
      tick();
      chk("t6_fresh_dn_req", dn_req, 1'b1);
      wait_done(50);
      chk("t6_fresh_rd1", up_data_read[31:16], 16'h1234);
      chk("t6_fresh_ack", up_ack, 3'b010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
